multicycle_control_unit: RTL

- Multi-cycle successor to the single-cycle MIPS decoder: one FSM sequences fetch, decode, execute, memory and writeback over several clocks.
- Supports R-type (SLL, SRL, ADD, SUBTRACT, AND, OR, XOR, NOR, SET_LESS_THAN, MULT), ADDI, LW, SW, BEQ and J.
- Adds a memory ready/request handshake and a parametrised multi-cycle MULT stall.
- Sits between the instruction register, the ALU/hi-lo unit, the shared memory port and the PC register.

---
 rtl/mips_defs.sv | 85 ++++++++
 rtl/mult_stall_counter.sv | 31 +++
 rtl/multicycle_control_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the multi-cycle MIPS control path: opcode and funct
// codes, the FSM state set, PC / write-data select encodings and the
// instruction classifier used by the control unit.
package mips_defs;

  // Opcodes (instruction register [31:26])
  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // Funct codes (instruction register [5:0]); these double as ALU op codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_NOOP = 6'b111111;

  // ALU op for add-immediate shares the ADDI opcode value
  localparam logic [5:0] ALU_ADDI = 6'b001000;

  // PC source select
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // Register-file write data select
  localparam logic [1:0] RWD_ALU = 2'd0;
  localparam logic [1:0] RWD_MEM = 2'd1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MULT_WAIT, S_MEM, S_WB
  } state_t;

  // Instruction classes the FSM branches on
  typedef enum logic [2:0] {
    C_ALU_R, C_MULT, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILLEGAL
  } iclass_t;

  function automatic iclass_t classify(input logic [5:0] op,
                                       input logic [5:0] fn,
                                       input logic       enable_mult);
    iclass_t cls;
    cls = C_ILLEGAL;
    case (op)
      OP_R_TYPE: begin
        case (fn)
          FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND,
          FN_OR, FN_XOR, FN_NOR, FN_SLT: cls = C_ALU_R;
          FN_MULT: cls = enable_mult ? C_MULT : C_ILLEGAL;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_J:    cls = C_J;
      OP_BEQ:  cls = C_BEQ;
      OP_ADDI: cls = C_ADDI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      default: cls = C_ILLEGAL;
    endcase
    return cls;
  endfunction

  // ALU operation used by EXEC and held through MEM
  function automatic logic [5:0] exec_alu_op(input iclass_t cls, input logic [5:0] fn);
    logic [5:0] op;
    case (cls)
      C_LW, C_SW: op = FN_ADD;
      C_BEQ:      op = FN_SUB;
      C_ADDI:     op = ALU_ADDI;
      C_ALU_R:    op = fn;
      default:    op = FN_NOOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mult_stall_counter.sv
// Down-counter that times the MULT_WAIT stall. Loaded with MULT_CYCLES-1 on
// entry; done is high while the count is zero, i.e. in the last stall cycle.
module mult_stall_counter #(
  parameter  int MULT_CYCLES = 4,
  localparam int CNT_W       = $clog2(MULT_CYCLES) + 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [CNT_W-1:0] count_q;

  // Count register: load has priority, decrement saturates at zero
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_W'(MULT_CYCLES - 1);
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory and
// writeback, handshakes with the shared memory port and stalls for MULT.
// MULT_CYCLES must lie in 1..16.
module multicycle_control_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter bit ENABLE_MULT = 1'b1,
  parameter int ALU_CTRL_W  = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  alu_zero,
  input  logic                  mem_ready,
  output logic                  instr_mem_req,
  output logic                  data_mem_req,
  output logic                  data_memory_write_enable,
  output logic                  ir_write_enable,
  output logic                  pc_write_enable,
  output logic [1:0]            PC_sel,
  output logic                  write_addr3_sel,
  output logic                  reg_write_enable,
  output logic [1:0]            reg_write_data_sel,
  output logic                  alu_src_b_sel,
  output logic                  hi_lo_write_enable,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  instr_retire,
  output logic                  illegal_op
);

  state_t     state_q, state_d;
  logic [5:0] op_q, funct_q;
  iclass_t    live_cls, held_cls;
  logic       cnt_load, cnt_done;
  logic [5:0] alu_op;

  // DECODE sees the freshly loaded IR; later states use the latched copy so
  // the IR may change underneath them without effect.
  assign live_cls = classify(opcode, funct, ENABLE_MULT);
  assign held_cls = classify(op_q, funct_q, ENABLE_MULT);

  mult_stall_counter #(.MULT_CYCLES(MULT_CYCLES)) u_mult_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (cnt_load),
    .dec     (state_q == S_MULT_WAIT),
    .done    (cnt_done)
  );

  // State register and instruction latch
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
    end
  end

  // Next-state logic and MULT counter load
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_load = 1'b0;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (live_cls)
          C_J, C_ILLEGAL: state_d = S_FETCH;
          C_MULT: begin
            cnt_load = 1'b1;
            state_d  = S_MULT_WAIT;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (held_cls)
          C_BEQ:      state_d = S_FETCH;
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM:       if (mem_ready) state_d = (held_cls == C_LW) ? S_WB : S_FETCH;
      S_WB:        state_d = S_FETCH;
      S_MULT_WAIT: if (cnt_done) state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode; every strobe is forced low while reset_n is low
  always_comb begin
    instr_mem_req            = 1'b0;
    data_mem_req             = 1'b0;
    data_memory_write_enable = 1'b0;
    ir_write_enable          = 1'b0;
    pc_write_enable          = 1'b0;
    PC_sel                   = PC_PLUS4;
    write_addr3_sel          = 1'b0;
    reg_write_enable         = 1'b0;
    reg_write_data_sel       = RWD_ALU;
    alu_src_b_sel            = 1'b0;
    hi_lo_write_enable       = 1'b0;
    alu_op                   = FN_NOOP;
    instr_retire             = 1'b0;
    illegal_op               = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          instr_mem_req = 1'b1;
          if (mem_ready) begin
            ir_write_enable = 1'b1;
            pc_write_enable = 1'b1;
          end
        end
        S_DECODE: begin
          case (live_cls)
            C_J: begin
              pc_write_enable = 1'b1;
              PC_sel          = PC_JUMP;
              instr_retire    = 1'b1;
            end
            C_ILLEGAL: begin
              illegal_op   = 1'b1;
              instr_retire = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          alu_op        = exec_alu_op(held_cls, funct_q);
          alu_src_b_sel = (held_cls == C_ADDI) || (held_cls == C_LW) || (held_cls == C_SW);
          if (held_cls == C_BEQ) begin
            PC_sel          = PC_BRANCH;
            pc_write_enable = alu_zero;
            instr_retire    = 1'b1;
          end
        end
        S_MEM: begin
          alu_op                   = exec_alu_op(held_cls, funct_q);
          alu_src_b_sel            = 1'b1;
          data_mem_req             = 1'b1;
          data_memory_write_enable = (held_cls == C_SW);
          instr_retire             = mem_ready && (held_cls == C_SW);
        end
        S_WB: begin
          reg_write_enable   = 1'b1;
          instr_retire       = 1'b1;
          reg_write_data_sel = (held_cls == C_LW) ? RWD_MEM : RWD_ALU;
          write_addr3_sel    = (held_cls == C_ADDI) || (held_cls == C_LW);
        end
        S_MULT_WAIT: begin
          alu_op = FN_MULT;
          if (cnt_done) begin
            hi_lo_write_enable = 1'b1;
            instr_retire       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_control = ALU_CTRL_W'(alu_op);

endmodule
